bicubic_frame_ctrl: RTL and testbench
=====================================

// Module: bicubic_frame_ctrl
// PURPOSE
//  Frame sequencer in front of the bicubic line/window buffer. Accepts a raster source frame
//  on a valid/ready pixel stream and emits a fixed-length padded stream: (WIDTH+PAD_COLS) px/row
//  for HEIGHT source rows, then PAD_ROWS all-pad rows. Tracks SOF/EOL, flags framing errors and
//  pulses frame_done so the upsampler can be re-armed for back-to-back frames.
// PARAMETERS
//  WIDTH      `SRC_IMG_WIDTH   source pixels per row
//  HEIGHT     `SRC_IMG_HEIGHT  source rows per frame
//  PAD_COLS   3                pad pixels appended after each source row
//  PAD_ROWS   3                full pad rows appended after the last source row
//  DW         24               pixel width (RGB888)
//  PAD_VALUE  24'h000000       constant pad pixel
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   async active-low reset
//  en         in   1   arm; new frame accepted only in IDLE while en=1
//  s_valid    in   1   source pixel valid
//  s_ready    out  1   source pixel ready
//  s_data     in   DW  source pixel
//  s_sof      in   1   first pixel of frame (tuser)
//  s_eol      in   1   last pixel of row (tlast)
//  m_valid    out  1   padded pixel valid (to buffer axi_valid)
//  m_ready    in   1   buffer ready
//  m_data     out  DW  padded pixel
//  busy       out  1   state != IDLE
//  frame_done out  1   1-cycle pulse on DONE
//  err_sof    out  1   sticky: pixel dropped in IDLE without s_sof, or s_sof seen mid-frame
//  err_eol    out  1   sticky: s_eol mismatched with col==WIDTH-1
//  err_clr    in   1   clears err_sof/err_eol (clear wins over same-cycle set)
// BEHAVIOUR
//  Reset: state=IDLE, col/row/pad counters 0, last_px=0; s_ready=0, m_valid=0, m_data=PAD_VALUE,
//   busy=0, frame_done=0, err_*=0. Reset mid-frame aborts; no partial output after release.
//  Transfer = valid & ready on either side. m_valid never depends on m_ready.
//  IDLE: en=0 -> s_ready=0. en=1 -> s_ready=1; transfer with s_sof=0 dropped, err_sof set;
//   transfer with s_sof=1 is NOT consumed here: go ACTIVE with s_ready=0 that cycle (pixel held).
//  ACTIVE: combinational pass-through: m_valid=s_valid, s_ready=m_ready, m_data=s_data.
//   Each transfer: col++, last_px<=s_data. s_sof at col!=0 or row!=0 -> err_sof, pixel passed.
//   s_eol checked only (no control): (s_eol != (col==WIDTH-1)) -> err_eol.
//   Transfer at col==WIDTH-1 -> col=0, HPAD.
//  HPAD: s_ready=0, m_valid=1, m_data=pad pixel; pad++ per transfer; after PAD_COLS transfers
//   pad=0; row++; row==HEIGHT-1 -> VPAD else ACTIVE.
//  VPAD: s_ready=0, m_valid=1, m_data=PAD_VALUE; col wraps at WIDTH+PAD_COLS-1, row++ on wrap;
//   after PAD_ROWS*(WIDTH+PAD_COLS) transfers -> DONE.
//  DONE: m_valid=0, s_ready=0, frame_done=1 for one cycle -> IDLE (counters cleared). en is
//   sampled only in IDLE; deasserting en mid-frame has no effect.
//  PAD_ROWS=0 -> DONE direct from last HPAD. Total m transfers/frame=(WIDTH+PAD_COLS)*(HEIGHT+PAD_ROWS).
//  Counters sized $clog2(WIDTH+PAD_COLS), $clog2(HEIGHT+PAD_ROWS), $clog2(PAD_COLS+1); no overflow.
// CONFIGURATION
//  BCCI_EDGE_REPLICATE_EN defined: HPAD pixel = last_px (right-edge replicate of current row).
//  Undefined: HPAD pixel = PAD_VALUE; last_px register removed. VPAD always PAD_VALUE.
// STRUCTURE
//  define.v: SRC_IMG_WIDTH/HEIGHT, state encodings BFC_IDLE/ACTIVE/HPAD/VPAD/DONE (3b).
//  Flops via dfflr/dffl from dffs.v. No sub-module; single FSM + counters.
// TESTING (WIDTH=4, HEIGHT=2, PAD_COLS=3, PAD_ROWS=3, m_ready=1)
//  Frame px 1..8, sof on px1, eol on px4/px8 -> 35 m transfers: 1,2,3,4,P,P,P,5..8,P,P,P,21xP;
//   frame_done pulse 1 cycle after 35th; err_*=0.
//  Same with BCCI_EDGE_REPLICATE_EN -> HPAD emits 4,4,4 and 8,8,8; VPAD emits 0.
//  Random m_ready (50%) and s_valid gaps -> identical 35-pixel sequence, no dup/drop; m_valid
//   held stable and m_data unchanged while m_ready=0.
//  en=1, 2 px without sof then a frame -> 2 dropped, err_sof=1, frame correct; err_clr -> 0.
//  eol on px3 instead of px4 -> err_eol=1, output sequence unchanged; back-to-back second frame
//   accepted after frame_done with no lost pixel.
//  Assert rst_n at transfer 10 -> all outputs at reset values; next sof frame yields 35 transfers.

Source files
------------

// File: rtl/bicubic_frame_ctrl_pkg.sv
// Shared types and sizing helpers for the bicubic frame sequencer.
// Provides the default source geometry and the FSM state encoding.
package bicubic_frame_ctrl_pkg;

  localparam int SRC_IMG_WIDTH  = 4;
  localparam int SRC_IMG_HEIGHT = 2;

  typedef enum logic [2:0] {
    BFC_IDLE   = 3'd0,
    BFC_ACTIVE = 3'd1,
    BFC_HPAD   = 3'd2,
    BFC_VPAD   = 3'd3,
    BFC_DONE   = 3'd4
  } bfc_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bicubic_frame_ctrl.sv
// Frame sequencer: passes source rows through and appends right/bottom padding.
// Optional macro BCCI_EDGE_REPLICATE_EN: right pad repeats the row's last source pixel.
module bicubic_frame_ctrl
  import bicubic_frame_ctrl_pkg::*;
#(
  parameter int             WIDTH     = SRC_IMG_WIDTH,
  parameter int             HEIGHT    = SRC_IMG_HEIGHT,
  parameter int             PAD_COLS  = 3,
  parameter int             PAD_ROWS  = 3,
  parameter int             DW        = 24,
  parameter logic [DW-1:0]  PAD_VALUE = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_sof,
  input  logic          s_eol,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          busy,
  output logic          frame_done,
  output logic          err_sof,
  output logic          err_eol,
  input  logic          err_clr
);

  localparam int ROW_LEN = WIDTH + PAD_COLS;
  localparam int CW      = cnt_w(ROW_LEN);
  localparam int RW      = cnt_w(HEIGHT + PAD_ROWS);
  localparam int PW      = cnt_w(PAD_COLS + 1);

  bfc_state_e     state_r, state_nx_s;
  logic [CW-1:0]  col_r, col_nx_s;
  logic [RW-1:0]  row_r, row_nx_s;
  logic [PW-1:0]  pad_r, pad_nx_s;
  logic           run_r;
  logic           err_sof_r, err_eol_r;
  logic           err_sof_set_s, err_eol_set_s;
  logic           s_ready_s, m_valid_s;
  logic [DW-1:0]  m_data_s, hpad_px_s;
  logic           col_last_s, pad_last_s;

  assign col_last_s = (col_r == CW'(WIDTH - 1));
  assign pad_last_s = (pad_r == PW'(PAD_COLS - 1));

`ifdef BCCI_EDGE_REPLICATE_EN
  logic [DW-1:0] last_px_r;

  // Remember the most recent accepted source pixel for right-edge replication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_px_r <= {DW{1'b0}};
    end else if ((state_r == BFC_ACTIVE) && s_valid && m_ready) begin
      last_px_r <= s_data;
    end else begin
      last_px_r <= last_px_r;
    end
  end

  assign hpad_px_s = last_px_r;
`else
  assign hpad_px_s = PAD_VALUE;
`endif

  // Next-state, counter and handshake decode
  always_comb begin
    state_nx_s    = state_r;
    col_nx_s      = col_r;
    row_nx_s      = row_r;
    pad_nx_s      = pad_r;
    s_ready_s     = 1'b0;
    m_valid_s     = 1'b0;
    m_data_s      = PAD_VALUE;
    err_sof_set_s = 1'b0;
    err_eol_set_s = 1'b0;
    case (state_r)
      BFC_IDLE: begin
        if (en && run_r) begin
          // A start-of-frame pixel is held so ACTIVE can forward it
          s_ready_s = !(s_valid && s_sof);
          if (s_valid && s_sof) begin
            state_nx_s = BFC_ACTIVE;
          end else if (s_valid) begin
            err_sof_set_s = 1'b1;
          end else begin
            state_nx_s = BFC_IDLE;
          end
        end else begin
          state_nx_s = BFC_IDLE;
        end
      end
      BFC_ACTIVE: begin
        m_valid_s = s_valid;
        s_ready_s = m_ready;
        m_data_s  = s_data;
        if (s_valid && m_ready) begin
          if (s_sof && ((col_r != {CW{1'b0}}) || (row_r != {RW{1'b0}}))) begin
            err_sof_set_s = 1'b1;
          end else begin
            err_sof_set_s = 1'b0;
          end
          if (s_eol != col_last_s) begin
            err_eol_set_s = 1'b1;
          end else begin
            err_eol_set_s = 1'b0;
          end
          if (col_last_s) begin
            col_nx_s   = {CW{1'b0}};
            state_nx_s = BFC_HPAD;
          end else begin
            col_nx_s = col_r + CW'(1);
          end
        end else begin
          state_nx_s = BFC_ACTIVE;
        end
      end
      BFC_HPAD: begin
        m_valid_s = 1'b1;
        m_data_s  = hpad_px_s;
        if (m_ready) begin
          if (pad_last_s) begin
            pad_nx_s = {PW{1'b0}};
            if (row_r != RW'(HEIGHT - 1)) begin
              row_nx_s   = row_r + RW'(1);
              state_nx_s = BFC_ACTIVE;
            end else if (PAD_ROWS == 0) begin
              state_nx_s = BFC_DONE;
            end else begin
              row_nx_s   = row_r + RW'(1);
              state_nx_s = BFC_VPAD;
            end
          end else begin
            pad_nx_s = pad_r + PW'(1);
          end
        end else begin
          state_nx_s = BFC_HPAD;
        end
      end
      BFC_VPAD: begin
        m_valid_s = 1'b1;
        m_data_s  = PAD_VALUE;
        if (m_ready) begin
          if (col_r == CW'(ROW_LEN - 1)) begin
            col_nx_s = {CW{1'b0}};
            if (row_r == RW'(HEIGHT + PAD_ROWS - 1)) begin
              state_nx_s = BFC_DONE;
            end else begin
              row_nx_s = row_r + RW'(1);
            end
          end else begin
            col_nx_s = col_r + CW'(1);
          end
        end else begin
          state_nx_s = BFC_VPAD;
        end
      end
      BFC_DONE: begin
        state_nx_s = BFC_IDLE;
        col_nx_s   = {CW{1'b0}};
        row_nx_s   = {RW{1'b0}};
        pad_nx_s   = {PW{1'b0}};
      end
      default: begin
        state_nx_s = BFC_IDLE;
        col_nx_s   = {CW{1'b0}};
        row_nx_s   = {RW{1'b0}};
        pad_nx_s   = {PW{1'b0}};
      end
    endcase
  end

  // State and position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BFC_IDLE;
      col_r   <= {CW{1'b0}};
      row_r   <= {RW{1'b0}};
      pad_r   <= {PW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      col_r   <= col_nx_s;
      row_r   <= row_nx_s;
      pad_r   <= pad_nx_s;
    end
  end

  // Keeps s_ready low through reset and the first cycle after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Sticky framing errors; a clear beats a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sof_r <= 1'b0;
      err_eol_r <= 1'b0;
    end else if (err_clr) begin
      err_sof_r <= 1'b0;
      err_eol_r <= 1'b0;
    end else begin
      err_sof_r <= err_sof_r | err_sof_set_s;
      err_eol_r <= err_eol_r | err_eol_set_s;
    end
  end

  assign s_ready    = s_ready_s;
  assign m_valid    = m_valid_s;
  assign m_data     = m_data_s;
  assign busy       = (state_r != BFC_IDLE);
  assign frame_done = (state_r == BFC_DONE);
  assign err_sof    = err_sof_r;
  assign err_eol    = err_eol_r;

endmodule

// File: tb/tb_bicubic_frame_ctrl.sv
// Directed self-checking bench for bicubic_frame_ctrl (4x2 source, 3 pad cols/rows).
module tb_bicubic_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int PC = 3;
  localparam int PR = 3;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n, en, s_valid, s_sof, s_eol, m_ready, err_clr;
  logic [DW-1:0] s_data;
  logic          s_ready, m_valid, busy, frame_done, err_sof, err_eol;
  logic [DW-1:0] m_data;

  bicubic_frame_ctrl #(
    .WIDTH(W), .HEIGHT(H), .PAD_COLS(PC), .PAD_ROWS(PR), .DW(DW), .PAD_VALUE(24'h000000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .frame_done(frame_done), .err_sof(err_sof), .err_eol(err_eol),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  int            cyc = 0;
  int            last_xfer_cyc = 0;
  int            done_cyc = 0;
  int            done_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          rand_rdy = 1'b0;
  logic          abort = 1'b0;

  // Output monitor: collects transfers, frame_done pulses and back-pressure stability
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_data", {8'd0, m_data}, {8'd0, stall_data});
      end
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        last_xfer_cyc <= cyc;
      end
      if (frame_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      stall_prev <= m_valid && !m_ready;
      stall_data <= m_data;
    end
  end

  // Sink ready: constant 1 or 50% random
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic drive_px(input logic [DW-1:0] d, input logic sof, input logic eol, input int gap);
    bit hit = 1'b0;
    if (abort) return;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
    for (int t = 0; t < 300 && !hit && !abort; t++) begin
      @(negedge clk);
      hit = s_valid && s_ready;
      @(posedge clk);
      #1;
    end
    if (!hit && !abort) check("src_timeout", 32'd0, 32'd1);
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
  endtask

  task automatic send_frame(input int base, input int eol_px, input bit gaps);
    for (int p = 1; p <= W * H; p++) begin
      drive_px(DW'(base + p), (p == 1), (p == eol_px) || (p == W * H), gaps ? $urandom_range(0, 2) : 0);
    end
  endtask

  task automatic push_exp(input int base);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) exp_q.push_back(DW'(base + r * W + c + 1));
      for (int k = 0; k < PC; k++) begin
`ifdef BCCI_EDGE_REPLICATE_EN
        exp_q.push_back(DW'(base + r * W + W));
`else
        exp_q.push_back(24'h000000);
`endif
      end
    end
    for (int k = 0; k < PR * (W + PC); k++) exp_q.push_back(24'h000000);
  endtask

  task automatic wait_done(input int target);
    for (int t = 0; t < 3000 && done_cnt < target; t++) @(negedge clk);
    if (done_cnt < target) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_cnt"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_px%0d", tag, i), {8'd0, got_q[i]}, {8'd0, exp_q[i]});
    end
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_m_data"}, {8'd0, m_data}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_err_sof"}, {31'd0, err_sof}, 32'd0);
    check({tag, "_err_eol"}, {31'd0, err_eol}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    s_data = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Nominal frame, sink always ready
    clear_q(); push_exp(0);
    send_frame(0, 4, 1'b0);
    wait_done(1);
    compare_q("basic");
    check("done_latency", done_cyc - last_xfer_cyc, 32'd1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 32'd1);
    check("basic_err_sof", {31'd0, err_sof}, 32'd0);
    check("basic_err_eol", {31'd0, err_eol}, 32'd0);
    check("basic_busy", {31'd0, busy}, 32'd0);

    // Random sink back-pressure and source gaps
    rand_rdy = 1'b1;
    clear_q(); push_exp(0);
    send_frame(0, 4, 1'b1);
    wait_done(1);
    rand_rdy = 1'b0;
    compare_q("rand");

    // Two stray pixels before start-of-frame are dropped
    clear_q();
    drive_px(24'h000064, 1'b0, 1'b0, 0);
    drive_px(24'h000065, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("drop_out_cnt", got_q.size(), 32'd0);
    check("drop_err_sof", {31'd0, err_sof}, 32'd1);
    push_exp(0);
    send_frame(0, 4, 1'b0);
    wait_done(1);
    compare_q("drop");
    check("drop_err_eol", {31'd0, err_eol}, 32'd0);
    pulse_clr();
    check("clr_err_sof", {31'd0, err_sof}, 32'd0);

    // Misplaced eol, then back-to-back second frame
    clear_q(); push_exp(0); push_exp(8);
    send_frame(0, 3, 1'b0);
    send_frame(8, 4, 1'b0);
    wait_done(2);
    compare_q("b2b");
    check("b2b_err_eol", {31'd0, err_eol}, 32'd1);
    check("b2b_err_sof", {31'd0, err_sof}, 32'd0);
    check("b2b_done_cnt", done_cnt, 32'd2);
    pulse_clr();
    check("clr_err_eol", {31'd0, err_eol}, 32'd0);

    // Reset in the middle of a frame
    clear_q();
    fork
      send_frame(0, 4, 1'b0);
      begin
        for (int t = 0; t < 500 && got_q.size() < 10; t++) @(negedge clk);
        check("mid_reach10", {31'd0, got_q.size() >= 10}, 32'd1);
        rst_n = 1'b0;
        abort = 1'b1;
      end
    join
    @(negedge clk);
    check_reset_outputs("mid");
    @(posedge clk); #1 rst_n = 1'b1; abort = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    clear_q(); push_exp(0);
    send_frame(0, 4, 1'b0);
    wait_done(1);
    compare_q("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
